prbs7_xnor_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 22 ++
 rtl/prbs7_xnor_lfsr.sv | 29 ++
 rtl/prbs7_xnor_checker.sv | 151 +++++++++++++++
 tb/tb_prbs7_xnor_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-7 XNOR definitions: checker state enum, tap positions, lockup pattern.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package prbs_pkg;

  localparam int PRBS_LEN = 7;
  localparam int TAP_A    = 6;
  localparam int TAP_B    = 5;
  localparam logic [PRBS_LEN-1:0] LOCKUP = 7'h7F;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // XNOR feedback: the all-ones state maps onto itself, so it never occurs in a live stream
  function automatic logic prbs_next_bit(input logic [PRBS_LEN-1:0] s);
    return ~(s[TAP_A] ^ s[TAP_B]);
  endfunction

endpackage

// File: rtl/prbs7_xnor_lfsr.sv
// PRBS-7 XNOR LFSR register; shifts in either an external bit or its own prediction.
// Latency: state updates one cycle after shift_en; pred is combinational from state.
// Backpressure: none; holds whenever shift_en is low.
module prbs7_xnor_lfsr
  import prbs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic                use_din,
  input  logic                din,
  output logic [PRBS_LEN-1:0] state,
  output logic                pred
);

  logic bit_in;

  assign pred   = prbs_next_bit(state);
  assign bit_in = use_din ? din : pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (shift_en) begin
      state <= {state[PRBS_LEN-2:0], bit_in};
    end
  end

endmodule

// File: rtl/prbs7_xnor_checker.sv
// PRBS-7 (x^7+x^6+1, XNOR) receive checker: self-seeds, verifies, locks, counts bit errors.
// Latency: err/locked/err_cnt registered, one cycle after the qualifying valid bit.
// Backpressure: none; din_valid low freezes state. Optional bit_cnt port under PRBS_CHK_BITCNT_EN.
module prbs7_xnor_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             din_valid,
  input  logic             din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  prbs_state_t         state;
  logic [2:0]          seed_cnt;
  logic [7:0]          match_cnt;
  logic [7:0]          miss_cnt;

  logic [PRBS_LEN-1:0] lfsr;
  logic                pred;
  logic                vld;
  logic                mismatch;
  logic                in_locked;
  logic                in_verify;
  logic                miss_last;
  logic                verify_fail;
  logic                unlock;
  logic [PRBS_LEN-1:0] seeded;

  assign vld         = en & din_valid;
  assign mismatch    = din ^ pred;
  assign in_locked   = (state == LOCKED);
  assign in_verify   = (state == VERIFY);
  assign miss_last   = (miss_cnt == 8'(UNLOCK_ERRS - 1));
  assign verify_fail = vld & in_verify & mismatch;
  assign unlock      = vld & in_locked & mismatch & miss_last;
  assign seeded      = {lfsr[PRBS_LEN-2:0], din};

  // Outside LOCKED the register follows the line; once locked it free-runs on its own prediction
  prbs7_xnor_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (vld),
    .use_din  (~in_locked),
    .din      (din),
    .state    (lfsr),
    .pred     (pred)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (clr_cnt) begin
        err_cnt <= '0;
      end
      if (!en) begin
        state     <= SEED;
        seed_cnt  <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
        locked    <= 1'b0;
      end else if (din_valid) begin
        case (state)
          SEED: begin
            if (seed_cnt == 3'(PRBS_LEN - 1)) begin
              // A window of all ones cannot come from a healthy source; restart seeding
              if (seeded == LOCKUP) begin
                seed_cnt <= '0;
              end else begin
                seed_cnt <= seed_cnt + 3'd1;
                state    <= VERIFY;
              end
            end else begin
              seed_cnt <= seed_cnt + 3'd1;
            end
          end
          VERIFY: begin
            if (mismatch) begin
              seed_cnt  <= '0;
              match_cnt <= '0;
              state     <= SEED;
            end else begin
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt == 8'(LOCK_CNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (mismatch) begin
              err <= 1'b1;
              if (!clr_cnt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
              if (miss_last) begin
                state     <= SEED;
                locked    <= 1'b0;
                seed_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state <= SEED;
          end
        endcase
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr_cnt || !en || verify_fail || unlock) begin
      bit_cnt <= '0;
    end else if (vld && in_locked && (bit_cnt != '1)) begin
      bit_cnt <= bit_cnt + 32'd1;
    end
  end
`else
  // checked-bit counter not built in this configuration
`endif

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Scoreboard bench for prbs7_xnor_checker: directed stream scenarios push expected outputs,
// a monitor pops one entry per driven cycle and compares locked/err/err_cnt.
module tb_prbs7_xnor_checker;

  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  always #5 clk = ~clk;

  prbs7_xnor_checker #(
    .LOCK_CNT    (8),
    .UNLOCK_ERRS (4),
    .ERR_W       (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .din_valid (din_valid),
    .din       (din),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt   (bit_cnt)
`endif
  );

  typedef struct packed {
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  logic [6:0]       g;
  logic             exp_locked;
  logic             exp_err;
  logic [ERR_W-1:0] exp_cnt;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Source model: XNOR LFSR x^7+x^6+1 emitting its feedback bit
  function automatic logic gen_next();
    logic b;
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
    return b;
  endfunction

  // Inputs change on the falling edge; the expectation is for the rising edge that follows
  task automatic drive(input logic v, input logic d, input logic e, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    en        = e;
    clr_cnt   = c;
    q.push_back(exp_t'{exp_locked, exp_err, exp_cnt});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("locked",  32'(locked),  32'(e.locked));
      chk("err",     32'(err),     32'(e.err));
      chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
    end
  end

  initial begin
    logic b;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    exp_cnt    = '0;

    repeat (2) @(negedge clk);
    chk("reset_locked",  32'(locked),  0);
    chk("reset_err",     32'(err),     0);
    chk("reset_err_cnt", 32'(err_cnt), 0);
`ifdef PRBS_CHK_BITCNT_EN
    chk("reset_bit_cnt", 32'(bit_cnt), 0);
`endif
    rst_n = 1'b1;
    en    = 1'b1;

    // Clean stream from seed 0: 7 seed bits + 8 verify bits, lock visible after bit 15
    g = 7'h00;
    for (int k = 1; k <= 20; k++) begin
      exp_locked = (k >= 15);
      drive(1'b1, gen_next(), 1'b1, 1'b0);
    end

    // Single inverted bit at stream position 40
    for (int k = 21; k <= 45; k++) begin
      b          = gen_next();
      exp_locked = 1'b1;
      exp_err    = (k == 40);
      if (k == 40) exp_cnt = exp_cnt + ERR_W'(1);
      drive(1'b1, b ^ (k == 40), 1'b1, 1'b0);
    end

    // Four consecutive inverted bits: lock lost after the fourth
    for (int k = 1; k <= 4; k++) begin
      b          = gen_next();
      exp_err    = 1'b1;
      exp_cnt    = exp_cnt + ERR_W'(1);
      exp_locked = (k < 4);
      drive(1'b1, ~b, 1'b1, 1'b0);
    end
    exp_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_locked = (k >= 15);
      drive(1'b1, gen_next(), 1'b1, 1'b0);
    end

    // Enable drop forces SEED; then seven ones must not enter VERIFY
    exp_locked = 1'b0;
    drive(1'b1, gen_next(), 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
    end
    for (int k = 1; k <= 20; k++) begin
      exp_locked = (k >= 15);
      drive(1'b1, gen_next(), 1'b1, 1'b0);
    end

    // First scenario again with din_valid toggling and junk on invalid cycles
    exp_locked = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    g = 7'h00;
    for (int k = 1; k <= 20; k++) begin
      b          = gen_next();
      exp_locked = (k >= 15);
      drive(1'b1, b, 1'b1, 1'b0);
      drive(1'b0, ~b, 1'b1, 1'b0);
    end

    // Alternating error/good bits drive err_cnt into saturation without unlocking
    for (int k = 1; k <= 20; k++) begin
      b       = gen_next();
      exp_err = 1'b1;
      if (exp_cnt != '1) exp_cnt = exp_cnt + ERR_W'(1);
      drive(1'b1, ~b, 1'b1, 1'b0);
      exp_err = 1'b0;
      drive(1'b1, gen_next(), 1'b1, 1'b0);
    end

    // Clear coincident with an error: count cleared, pulse still seen
    exp_err = 1'b1;
    exp_cnt = '0;
    drive(1'b1, ~gen_next(), 1'b1, 1'b1);
    exp_err = 1'b0;
    drive(1'b1, gen_next(), 1'b1, 1'b0);
    exp_err = 1'b1;
    exp_cnt = ERR_W'(1);
    drive(1'b1, ~gen_next(), 1'b1, 1'b0);
    exp_err = 1'b0;
    exp_cnt = '0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    exp_err = 1'b1;
    exp_cnt = ERR_W'(1);
    drive(1'b1, ~gen_next(), 1'b1, 1'b0);

    // Asynchronous reset between edges while locked with err high
    @(posedge clk);
    #3;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_locked",  32'(locked),  0);
    chk("async_rst_err",     32'(err),     0);
    chk("async_rst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
